// File: rtl/lsu.sv
// Load/store unit: captures one operation, performs at most one data-bus access
// and returns a single-cycle writeback beat carrying misalignment/timeout status.
module lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM       = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_mem_en,
    input  logic                       i_mem_rd_wr,
    input  logic [1:0]                 i_size,
    input  logic                       i_unsigned,
    input  logic [DATA_WIDTH-1:0]      i_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_store_data,
    input  logic                       i_rf_wr_en,
    input  logic [$clog2(REG_NUM)-1:0] i_rd_addr,
    input  logic [ADDRESS_WIDTH-1:0]   i_pc,
    input  logic                       i_ecall,
    output logic                       o_dmem_req,
    input  logic                       i_dmem_gnt,
    output logic [DATA_WIDTH-1:0]      o_dmem_addr,
    output logic                       o_dmem_we,
    output logic [DATA_WIDTH/8-1:0]    o_dmem_be,
    output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
    input  logic                       i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
    output logic                       o_valid,
    output logic                       o_rf_wr_en,
    output logic [$clog2(REG_NUM)-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_wb_data,
    output logic [ADDRESS_WIDTH-1:0]   o_pc,
    output logic                       o_ecall,
    output logic                       o_misaligned,
    output logic                       o_timeout
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] LANE_MASK = DATA_WIDTH'(BW - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [CW-1:0]                r_cnt;
    logic [DATA_WIDTH-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]        r_sdata;
    logic [DATA_WIDTH-1:0]        r_wb_data;
    logic [1:0]                   r_size;
    logic                         r_store;
    logic                         r_unsigned;
    logic                         r_rf_wr_en;
    logic [$clog2(REG_NUM)-1:0]   r_rd_addr;
    logic [ADDRESS_WIDTH-1:0]     r_pc;
    logic                         r_ecall;
    logic                         r_misaligned;
    logic                         r_timeout;

    logic                         w_misaligned;
    logic                         w_expire;
    logic                         w_in_req;
    logic                         w_done;
    logic [DATA_WIDTH-1:0]        w_shifted;
    logic [DATA_WIDTH-1:0]        w_load;
    logic [BW-1:0]                w_mask;
    logic [DATA_WIDTH-1:0]        w_wdata;

    // Only real memory accesses can be misaligned; an ALU pass-through carries a result, not an address.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = i_mem_addr[0];
            2'b10:   w_misaligned = |i_mem_addr[1:0];
            default: w_misaligned = (DATA_WIDTH == 32) ? 1'b1 : |i_mem_addr[2:0];
        endcase
        w_misaligned = w_misaligned & i_mem_en;
    end

    assign w_expire = (r_cnt >= TMO_LAST);
    assign w_in_req = (r_state == REQ);
    assign w_done   = (r_state == DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_valid) w_next = (!i_mem_en || w_misaligned) ? DONE : REQ;
            REQ: begin
                if (i_dmem_gnt)    w_next = r_store ? DONE : RESP;
                else if (w_expire) w_next = DONE;
            end
            RESP: if (i_dmem_rvalid || w_expire) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_sdata      <= '0;
            r_wb_data    <= '0;
            r_size       <= '0;
            r_store      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_rf_wr_en   <= 1'b0;
            r_rd_addr    <= '0;
            r_pc         <= '0;
            r_ecall      <= 1'b0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (i_valid) begin
                    r_cnt        <= '0;
                    r_addr       <= i_mem_addr;
                    r_sdata      <= i_store_data;
                    r_wb_data    <= i_mem_addr;
                    r_size       <= i_size;
                    r_store      <= i_mem_en & i_mem_rd_wr;
                    r_unsigned   <= i_unsigned;
                    r_rf_wr_en   <= i_rf_wr_en;
                    r_rd_addr    <= i_rd_addr;
                    r_pc         <= i_pc;
                    r_ecall      <= i_ecall;
                    r_misaligned <= w_misaligned;
                    r_timeout    <= 1'b0;
                end
                REQ: begin
                    if (!i_dmem_gnt && w_expire) r_timeout <= 1'b1;
                    else                         r_cnt     <= r_cnt + 1'b1;
                end
                RESP: begin
                    if (i_dmem_rvalid)  r_wb_data <= w_load;
                    else if (w_expire)  r_timeout <= 1'b1;
                    else                r_cnt     <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = i_dmem_rdata >> {r_addr[OW-1:0], 3'b000};
        case (r_size)
            2'b00:   w_load = r_unsigned ? DATA_WIDTH'(w_shifted[7:0])  : DATA_WIDTH'($signed(w_shifted[7:0]));
            2'b01:   w_load = r_unsigned ? DATA_WIDTH'(w_shifted[15:0]) : DATA_WIDTH'($signed(w_shifted[15:0]));
            2'b10:   w_load = r_unsigned ? DATA_WIDTH'(w_shifted[31:0]) : DATA_WIDTH'($signed(w_shifted[31:0]));
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00: begin
                w_mask  = BW'(1);
                w_wdata = {BW{r_sdata[7:0]}};
            end
            2'b01: begin
                w_mask  = BW'(3);
                w_wdata = {(BW / 2){r_sdata[15:0]}};
            end
            2'b10: begin
                w_mask  = BW'(15);
                w_wdata = {(BW / 4){r_sdata[31:0]}};
            end
            default: begin
                w_mask  = '1;
                w_wdata = r_sdata;
            end
        endcase
    end

    assign o_ready      = (r_state == IDLE);
    assign o_dmem_req   = w_in_req;
    assign o_dmem_addr  = w_in_req ? (r_addr & ~LANE_MASK) : '0;
    assign o_dmem_we    = w_in_req & r_store;
    assign o_dmem_be    = !w_in_req ? '0 : (r_store ? (w_mask << r_addr[OW-1:0]) : '1);
    assign o_dmem_wdata = (w_in_req && r_store) ? w_wdata : '0;

    assign o_valid      = w_done;
    assign o_rf_wr_en   = w_done & r_rf_wr_en & ~r_misaligned & ~r_timeout & ~r_store;
    assign o_rd_addr    = w_done ? r_rd_addr : '0;
    assign o_wb_data    = w_done ? r_wb_data : '0;
    assign o_pc         = w_done ? r_pc : '0;
    assign o_ecall      = w_done & r_ecall;
    assign o_misaligned = w_done & r_misaligned;
    assign o_timeout    = w_done & r_timeout;
endmodule
